// File: rtl/crc_pkg.sv
// Shared state encoding, standard polynomials and sizing helpers for the CRC engine.
package crc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } crc_state_t;

  localparam logic [6:0]  CRC7_SD_POLY     = 7'h09;
  localparam logic [15:0] CRC16_CCITT_POLY = 16'h1021;

  // Counter width for N steps; a single-step engine still needs one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/crc_step.sv
// Combinational fold of NBITS message bits (MSB first) into a CRC remainder.
module crc_step
  import crc_pkg::*;
#(
  parameter int               CRC_W = 7,
  parameter logic [CRC_W-1:0] POLY  = CRC7_SD_POLY,
  parameter int               NBITS = 1
) (
  input  logic [CRC_W-1:0] rem_in,
  input  logic [NBITS-1:0] bits_in,
  output logic [CRC_W-1:0] rem_out
);

  logic [CRC_W-1:0] rem_v;
  logic             fb;

  always_comb begin
    rem_v = rem_in;
    fb    = 1'b0;
    for (int i = 0; i < NBITS; i++) begin
      fb    = rem_v[CRC_W-1] ^ bits_in[NBITS-1-i];
      rem_v = (rem_v << 1) ^ (fb ? POLY : '0);
    end
    rem_out = rem_v;
  end

endmodule

// File: rtl/crc_engine.sv
// Multi-cycle parametrised CRC generator with message chaining for the SD/SPI path.
module crc_engine
  import crc_pkg::*;
#(
  parameter int               CRC_W          = 7,
  parameter logic [CRC_W-1:0] POLY           = CRC7_SD_POLY,
  parameter int               DATA_W         = 40,
  parameter int               BITS_PER_CYCLE = 1,
  parameter logic [CRC_W-1:0] INIT           = '0,
  parameter logic [CRC_W-1:0] XOR_OUT        = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              chain,
  input  logic [DATA_W-1:0] data_in,
  output logic              ready,
  output logic [CRC_W-1:0]  crc_out,
  output logic              valid
);

  localparam int N     = DATA_W / BITS_PER_CYCLE;
  localparam int CNT_W = cnt_width(N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  if (CRC_W < 1 || CRC_W > 32) begin : g_bad_crc_w
    $error("crc_engine: CRC_W must be in 1..32");
  end
  if (BITS_PER_CYCLE < 1 || BITS_PER_CYCLE > DATA_W) begin : g_bad_bpc_range
    $error("crc_engine: BITS_PER_CYCLE must be in 1..DATA_W");
  end else if (DATA_W % BITS_PER_CYCLE != 0) begin : g_bad_bpc_div
    $error("crc_engine: BITS_PER_CYCLE must divide DATA_W");
  end

  crc_state_t        state_q;
  logic [CRC_W-1:0]  rem_q;
  logic [CRC_W-1:0]  rem_d;
  logic [DATA_W-1:0] shreg_q;
  logic [DATA_W-1:0] shreg_d;
  logic [CNT_W-1:0]  cnt_q;

  crc_step #(
    .CRC_W (CRC_W),
    .POLY  (POLY),
    .NBITS (BITS_PER_CYCLE)
  ) u_step (
    .rem_in  (rem_q),
    .bits_in (shreg_q[DATA_W-1 -: BITS_PER_CYCLE]),
    .rem_out (rem_d)
  );

  assign shreg_d = shreg_q << BITS_PER_CYCLE;

  // rem_q keeps the raw remainder; XOR_OUT is applied only on the output so chaining stays exact.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= INIT;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (load) begin
            shreg_q <= data_in;
            cnt_q   <= '0;
            state_q <= BUSY;
            if (!chain) begin
              rem_q <= INIT;
            end
          end
        end
        BUSY: begin
          rem_q   <= rem_d;
          shreg_q <= shreg_d;
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready   = (state_q == IDLE) || (state_q == DONE);
  assign valid   = (state_q == DONE) && !load;
  assign crc_out = valid ? (rem_q ^ XOR_OUT) : '0;

endmodule

// File: tb/tb_crc_engine.sv
// Scoreboard bench: CRC7-SD engine, CRC16 byte engine, and a BITS_PER_CYCLE sweep vs a polynomial-division model.
module tb_crc_engine;

  typedef struct {
    logic [31:0] crc;
    int          cyc;
  } exp_t;

  localparam logic [15:0] INIT_S = 16'hFFFF;
  localparam logic [15:0] XOR_S  = 16'hFFFF;

  logic clk;
  int   cyc;
  int   n_cmp;
  int   n_fail;

  // default CRC7-SD engine
  logic        rst0, load0, chain0, ready0, valid0, vprev0;
  logic [39:0] data0;
  logic [6:0]  crc0;
  // CRC16 byte engine
  logic        rst1, load1, chain1, ready1, valid1, vprev1;
  logic [7:0]  data1;
  logic [15:0] crc1;
  // BITS_PER_CYCLE sweep
  logic        rst_s, load_s, chain_s;
  logic [39:0] data_s;
  logic [3:0]  ready_s, valid_s, vprev_s;
  logic [15:0] crc_s [4];

  exp_t q0[$];
  exp_t q1[$];
  exp_t qs[4][$];

  logic [31:0] rem_m0, rem_m1, rem_ms;
  logic [31:0] last_exp0;

  crc_engine u0 (
    .clk(clk), .rst(rst0), .load(load0), .chain(chain0), .data_in(data0),
    .ready(ready0), .crc_out(crc0), .valid(valid0)
  );

  crc_engine #(
    .CRC_W(16), .POLY(16'h1021), .DATA_W(8), .BITS_PER_CYCLE(8),
    .INIT(16'h0000), .XOR_OUT(16'h0000)
  ) u1 (
    .clk(clk), .rst(rst1), .load(load1), .chain(chain1), .data_in(data1),
    .ready(ready1), .crc_out(crc1), .valid(valid1)
  );

  for (genvar gi = 0; gi < 4; gi++) begin : g_sweep
    crc_engine #(
      .CRC_W(16), .POLY(16'h1021), .DATA_W(40), .BITS_PER_CYCLE(1 << gi),
      .INIT(INIT_S), .XOR_OUT(XOR_S)
    ) u_dut (
      .clk(clk), .rst(rst_s), .load(load_s), .chain(chain_s), .data_in(data_s),
      .ready(ready_s[gi]), .crc_out(crc_s[gi]), .valid(valid_s[gi])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no end, required summary");
    $fatal(1, "watchdog");
  end

  // New remainder = (R * x^l + D * x^w) mod G, by long division over GF(2).
  function automatic logic [31:0] crc_next(input logic [31:0] r, input logic [63:0] d,
                                           input int l, input int w, input logic [31:0] poly);
    logic [63:0] dv;
    logic [63:0] g;
    dv = (64'(r) << l) ^ (d << w);
    g  = (64'd1 << w) | 64'(poly);
    for (int i = l + w - 1; i >= w; i--) begin
      if (dv[i]) dv = dv ^ (g << (i - w));
    end
    return 32'(dv) & ((32'd1 << w) - 32'd1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    exp_t e;
    if (valid0 && !vprev0) begin
      if (q0.size() == 0) check("u0_unexpected_valid", 32'(valid0), 32'd0);
      else begin
        e = q0.pop_front();
        $display("[cyc %0d] u0 crc=%h exp=%h", cyc, crc0, e.crc);
        check("u0_crc", 32'(crc0), e.crc);
        check("u0_latency", 32'(cyc), 32'(e.cyc));
      end
    end
    if (valid1 && !vprev1) begin
      if (q1.size() == 0) check("u1_unexpected_valid", 32'(valid1), 32'd0);
      else begin
        e = q1.pop_front();
        $display("[cyc %0d] u1 crc=%h exp=%h", cyc, crc1, e.crc);
        check("u1_crc", 32'(crc1), e.crc);
        check("u1_latency", 32'(cyc), 32'(e.cyc));
      end
    end
    for (int k = 0; k < 4; k++) begin
      if (valid_s[k] && !vprev_s[k]) begin
        if (qs[k].size() == 0) check($sformatf("sw%0d_unexpected_valid", k), 32'(valid_s[k]), 32'd0);
        else begin
          e = qs[k].pop_front();
          $display("[cyc %0d] sweep bpc=%0d crc=%h exp=%h", cyc, 1 << k, crc_s[k], e.crc);
          check($sformatf("sw%0d_crc", k), 32'(crc_s[k]), e.crc);
          check($sformatf("sw%0d_latency", k), 32'(cyc), 32'(e.cyc));
        end
      end
    end
    vprev0  <= valid0;
    vprev1  <= valid1;
    vprev_s <= valid_s;
  end

  // ---------------- drivers (called at posedge + 1) ----------------
  task automatic wait_ready0(output int waited);
    waited = 0;
    while (ready0 !== 1'b1 && waited < 200) begin @(posedge clk); #1; waited++; end
    if (ready0 !== 1'b1) check("u0_ready_timeout", 32'(ready0), 32'd1);
  endtask

  task automatic issue0(input logic [39:0] d, input logic ch, input bit push);
    int w;
    wait_ready0(w);
    load0 = 1'b1; chain0 = ch; data0 = d;
    rem_m0    = crc_next(ch ? rem_m0 : 32'd0, 64'(d), 40, 7, 32'h09);
    last_exp0 = rem_m0;
    if (push) q0.push_back('{last_exp0, cyc + 41});
    #1;
    check("u0_valid_drop_on_load", 32'(valid0), 32'd0);
    check("u0_crc_zero_on_load", 32'(crc0), 32'd0);
    @(posedge clk); #1;
    load0 = 1'b0; chain0 = 1'b0;
  endtask

  task automatic finish0(input int exp_wait);
    int w;
    wait_ready0(w);
    check("u0_busy_cycles", 32'(w), 32'(exp_wait));
    @(posedge clk); #1;
  endtask

  task automatic wait_ready1(output int waited);
    waited = 0;
    while (ready1 !== 1'b1 && waited < 20) begin @(posedge clk); #1; waited++; end
    if (ready1 !== 1'b1) check("u1_ready_timeout", 32'(ready1), 32'd1);
  endtask

  task automatic issue1(input logic [7:0] d, input logic ch, input bit use_const,
                        input logic [15:0] const_crc);
    int w;
    wait_ready1(w);
    load1 = 1'b1; chain1 = ch; data1 = d;
    rem_m1 = crc_next(ch ? rem_m1 : 32'd0, 64'(d), 8, 16, 32'h1021);
    q1.push_back('{use_const ? 32'(const_crc) : rem_m1, cyc + 2});
    @(posedge clk); #1;
    load1 = 1'b0; chain1 = 1'b0;
    wait_ready1(w);
    check("u1_busy_cycles", 32'(w), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic issue_s(input logic [39:0] d, input logic ch);
    int w;
    w = 0;
    while (ready_s !== 4'hF && w < 200) begin @(posedge clk); #1; w++; end
    if (ready_s !== 4'hF) check("sw_ready_timeout", 32'(ready_s), 32'hF);
    load_s = 1'b1; chain_s = ch; data_s = d;
    rem_ms = crc_next(ch ? rem_ms : 32'(INIT_S), 64'(d), 40, 16, 32'h1021);
    for (int k = 0; k < 4; k++) qs[k].push_back('{rem_ms ^ 32'(XOR_S), cyc + (40 >> k) + 1});
    #1;
    check("sw_valid_drop_on_load", 32'(valid_s), 32'd0);
    @(posedge clk); #1;
    load_s = 1'b0; chain_s = 1'b0;
    w = 0;
    while (ready_s !== 4'hF && w < 200) begin @(posedge clk); #1; w++; end
    check("sw_slowest_busy_cycles", 32'(w), 32'd40);
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] r;
    string       msg;
    n_cmp = 0; n_fail = 0;
    rst0 = 1; load0 = 0; chain0 = 0; data0 = '0;
    rst1 = 1; load1 = 0; chain1 = 0; data1 = '0;
    rst_s = 1; load_s = 0; chain_s = 0; data_s = '0;
    rem_m0 = 0; rem_m1 = 0; rem_ms = 32'(INIT_S); last_exp0 = 0;
    repeat (3) @(posedge clk);
    #1;
    rst0 = 0; rst1 = 0; rst_s = 0;
    check("u0_reset_ready", 32'(ready0), 32'd1);
    check("u0_reset_valid", 32'(valid0), 32'd0);
    check("u0_reset_crc", 32'(crc0), 32'd0);
    check("u1_reset_ready", 32'(ready1), 32'd1);
    check("sw_reset_ready", 32'(ready_s), 32'hF);
    check("sw_reset_valid", 32'(valid_s), 32'd0);

    // CMD0 alone: known wire CRC7 0x4A
    issue0(40'h4000000000, 1'b0, 1'b1);
    check("u0_cmd0_model", last_exp0, 32'h4A);
    finish0(40);
    repeat (10) @(posedge clk);
    #1;
    check("u0_done_hold_valid", 32'(valid0), 32'd1);
    check("u0_done_hold_crc", 32'(crc0), 32'h4A);

    // CMD0 then CMD8 loaded in CMD0's first DONE cycle
    issue0(40'h4000000000, 1'b0, 1'b0);
    issue0(40'h48000001AA, 1'b0, 1'b1);
    check("u0_cmd8_model", last_exp0, 32'h43);
    finish0(40);

    // random messages with random chaining
    for (int i = 0; i < 16; i++) begin
      r = {$urandom(), $urandom()};
      issue0(r[39:0], 1'($urandom_range(0, 1)), 1'b1);
      finish0(40);
    end

    // load while BUSY is ignored and must not disturb the in-flight result
    r = {$urandom(), $urandom()};
    issue0(r[39:0], 1'b0, 1'b1);
    repeat (3) begin @(posedge clk); #1; end
    load0 = 1'b1; chain0 = 1'b0; data0 = ~r[39:0];
    repeat (4) begin @(posedge clk); #1; end
    check("u0_ready_low_busy", 32'(ready0), 32'd0);
    load0 = 1'b0;
    finish0(33);

    // reset mid-BUSY aborts; a chained load afterwards starts from INIT
    r = {$urandom(), $urandom()};
    issue0(r[39:0], 1'b0, 1'b0);
    repeat (5) begin @(posedge clk); #1; end
    rst0 = 1'b1;
    @(posedge clk); #1;
    rst0 = 1'b0;
    rem_m0 = 32'd0;
    check("u0_midbusy_rst_ready", 32'(ready0), 32'd1);
    check("u0_midbusy_rst_valid", 32'(valid0), 32'd0);
    check("u0_midbusy_rst_crc", 32'(crc0), 32'd0);
    r = {$urandom(), $urandom()};
    issue0(r[39:0], 1'b1, 1'b1);
    finish0(40);

    // CRC16 byte engine: "123456789" -> 0x31C3
    msg = "123456789";
    for (int i = 0; i < 9; i++) begin
      issue1(8'(msg[i]), (i != 0), (i == 8), 16'h31C3);
    end
    // 512 x 0xFF SD data block -> 0x7FA1
    for (int i = 0; i < 512; i++) begin
      issue1(8'hFF, (i != 0), (i == 511), 16'h7FA1);
    end

    // BITS_PER_CYCLE sweep with INIT/XOR_OUT = 0xFFFF
    for (int i = 0; i < 12; i++) begin
      r = {$urandom(), $urandom()};
      issue_s(r[39:0], (i != 0) ? 1'($urandom_range(0, 1)) : 1'b0);
    end

    repeat (5) @(posedge clk);
    #1;
    check("u0_queue_drained", 32'(q0.size()), 32'd0);
    check("u1_queue_drained", 32'(q1.size()), 32'd0);
    for (int k = 0; k < 4; k++) check($sformatf("sw%0d_queue_drained", k), 32'(qs[k].size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/crc_engine.md
# crc_engine

Parametrised, multi-cycle CRC generator for the SD-card/SPI path. It replaces the fixed CRC7-over-40-bit engine, generalising CRC width, polynomial, input word width, bits processed per cycle, initial value and output XOR. It adds message chaining, so multi-word payloads such as the 512-byte SD data-block CRC16 can be accumulated one word at a time. It sits between the SD command/data framers and the SPI shifter.

## Interface
- CRC_W, 7: CRC width in bits (1..32)
- POLY, 7'h09: generator polynomial, implicit x^CRC_W term omitted (CRC7-SD = 7'h09, CRC16-CCITT = 16'h1021)
- DATA_W, 40: input word width; MSB processed first
- BITS_PER_CYCLE, 1: bits folded per clock; must divide DATA_W (elaboration error otherwise)
- INIT, '0: remainder value at reset and at start of each non-chained message
- XOR_OUT, '0: value XORed onto the remainder to form crc_out
- clk  in  1  system clock; single clock domain
- rst  in  1  synchronous, active-high reset
- load  in  1  start processing data_in; accepted only when ready=1
- chain  in  1  sampled with an accepted load: 1 = continue from current raw remainder, 0 = start from INIT
- data_in  in  DATA_W  word to process, sampled on accepted load
- ready  out  1  engine can accept a load (IDLE or DONE)
- crc_out  out  CRC_W  final CRC (remainder ^ XOR_OUT) while valid; 0 otherwise
- valid  out  1  crc_out is valid

## Operation
- States (shared enum): IDLE (post-reset only), BUSY, DONE.
- Registers: rem[CRC_W] (raw remainder), shreg[DATA_W], cnt (0..N-1), with N = DATA_W/BITS_PER_CYCLE.
- Reset: state=IDLE, rem=INIT, shreg=0, cnt=0. Outputs: ready=1, valid=0, crc_out=0.
- Accepted load (load & ready): shreg<=data_in, cnt<=0, state<=BUSY, rem<=(chain ? rem : INIT).
- Chaining from IDLE uses rem=INIT. XOR_OUT never feeds back into rem.
- BUSY step, repeated BITS_PER_CYCLE times MSB-first inside one cycle: fb = rem[CRC_W-1] ^ shreg[DATA_W-1]; rem = (rem<<1) ^ (fb ? POLY : 0); shreg <<= 1.
- Result equals a standard non-reflected CRC (equivalent to dividing the message with CRC_W appended zeros when INIT=0).
- BUSY: cnt increments each cycle. When cnt==N-1, state<=DONE and cnt<=0.
- load during BUSY: ignored (ready=0). There is no queueing and no abort.
- DONE: crc_out = rem ^ XOR_OUT, valid = ~load, ready=1. DONE is held indefinitely until the next load.
- load in DONE: valid drops combinationally in that cycle and the next message starts as above.
- rst mid-BUSY: aborts immediately to reset values; the partial remainder is discarded.
- All arithmetic is modulo 2. cnt width is $clog2(N) with a minimum of 1 bit.

## Timing
- Load in cycle t → BUSY during cycles t+1..t+N → valid=1 from cycle t+N+1.
- Latency: N+1 cycles. With BITS_PER_CYCLE=DATA_W, valid appears 2 cycles after load.
- Back-to-back: a load asserted in the first DONE cycle gives one message per N+1 cycles.
- ready is combinational from state only; it never depends on load.
- crc_out and valid are combinational from state/rem (and load for valid). Consumers sample them on the clock edge.
- Critical path: one crc_step of BITS_PER_CYCLE XOR stages. Keep BITS_PER_CYCLE ≤ 8 on the FPGA target.

## Structure
- Package crc_pkg: state enum crc_state_t {IDLE, BUSY, DONE}; constants CRC7_SD_POLY=7'h09, CRC16_CCITT_POLY=16'h1021.
- Sub-module crc_step: purely combinational, parameters CRC_W, POLY, NBITS; ports rem_in, bits_in[NBITS], rem_out; unrolled per the BUSY step rule.
- The top module owns the FSM, counter, shift register and output logic.

## Test plan
- Default params, load data_in=40'h4000000000 (CMD0), chain=0 → valid at t+41, crc_out=7'h4A (wire byte 8'h95); ready=0 during BUSY.
- Default params, CMD8 40'h48000001AA loaded in the first DONE cycle of the previous message → valid drops that cycle, crc_out=7'h43 after 41 cycles.
- CRC_W=16, POLY=16'h1021, DATA_W=8, BITS_PER_CYCLE=8: ASCII "123456789", first byte chain=0, rest chain=1 → final crc_out=16'h31C3; each byte valid after 2 cycles.
- Same config, 512 bytes 8'hFF chained → crc_out=16'h7FA1 (SD data-block CRC).
- BITS_PER_CYCLE sweep {1,2,4,8} with DATA_W=40 on random data → results identical to the BITS_PER_CYCLE=1 model, latency N+1; INIT=16'hFFFF with XOR_OUT=16'hFFFF checked against the reference model.
- rst asserted mid-BUSY, and load during BUSY → reset values next cycle; the ignored load does not alter the in-flight result.
